// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes,
// FSM states and datapath mux selects (also used by the ALU control decoder).
package mips_ctrl_pkg;

  localparam int OP_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALUOP_AND    = 3'b000;
  localparam logic [2:0] ALUOP_OR     = 3'b001;
  localparam logic [2:0] ALUOP_BRANCH = 3'b010;
  localparam logic [2:0] ALUOP_ADD    = 3'b100;
  localparam logic [2:0] ALUOP_LUI    = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC     = 2'd2;

  localparam logic [1:0] ALUB_REG    = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_LINK     = 4'd12,
    S_JR       = 4'd13
  } state_t;

  function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      OP_ANDI: r = ALUOP_AND;
      OP_ORI:  r = ALUOP_OR;
      OP_LUI:  r = ALUOP_LUI;
      default: r = ALUOP_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_outputs.sv
// Combinational state -> control-word decoder; only FETCH looks at mem_ready,
// and BRANCH/EXEC_I look at the opcode latched in DECODE.
module multicycle_control_outputs
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic [5:0] i_opcode,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_branch_ne,
  output logic [1:0] o_pc_src,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op
);

  // Decode the control word for the current state
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_branch_ne     = 1'b0;
    o_pc_src        = PCSRC_ALU;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = REGDST_RT;
    o_mem_to_reg    = MEMTOREG_ALUOUT;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ALUB_REG;
    o_alu_op        = ALUOP_AND;
    case (i_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = ALUB_FOUR;
        o_alu_op    = ALUOP_ADD;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = ALUB_IMM_SH;
        o_alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_RTYPE;
      end
      S_WB_R: begin
        o_reg_dst   = REGDST_RD;
        o_reg_write = 1'b1;
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
        o_alu_op    = itype_alu_op(i_opcode);
      end
      S_WB_I, S_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = (i_state == S_WB_MEM) ? MEMTOREG_MDR : MEMTOREG_ALUOUT;
      end
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
        o_alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_BRANCH;
        o_pc_write_cond = 1'b1;
        o_pc_src        = PCSRC_ALUOUT;
        o_branch_ne     = (i_opcode == OP_BNE);
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_LINK_EN
      S_LINK: begin
        o_reg_dst    = REGDST_RA;
        o_mem_to_reg = MEMTOREG_PC;
        o_reg_write  = 1'b1;
        o_pc_write   = 1'b1;
        o_pc_src     = PCSRC_JUMP;
      end
      S_JR: begin
        o_pc_write = 1'b1;
        o_pc_src   = PCSRC_RS;
      end
`endif
      default: begin
        o_pc_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM. Define MULTICYCLE_LINK_EN to add JAL (LINK)
// and JR states; otherwise JAL is illegal and JR is an ordinary R-type.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH,
  parameter int     OP_WIDTH    = OP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_t              r_state;
  state_t              w_next_state;
  logic [OP_WIDTH-1:0] r_opcode;
  logic                r_illegal_op;
  logic                w_illegal;
  // The branch decision is made by the datapath; zero is not needed here.
  logic                w_unused_zero;

  assign w_unused_zero = zero;

`ifdef MULTICYCLE_LINK_EN
  logic [5:0] r_funct;
`else
  logic       w_unused_funct;
  assign w_unused_funct = ^funct;
`endif

  // Next-state selection; opcode is only consulted live in DECODE
  always_comb begin
    w_next_state = S_FETCH;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next_state = S_DECODE;
        else           w_next_state = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         w_next_state = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
          OP_J:                             w_next_state = S_JUMP;
`ifdef MULTICYCLE_LINK_EN
          OP_JAL:                           w_next_state = S_LINK;
`endif
          default: begin
            w_next_state = S_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
`ifdef MULTICYCLE_LINK_EN
        if (r_funct == FUNCT_JR) w_next_state = S_JR;
        else                     w_next_state = S_WB_R;
`else
        w_next_state = S_WB_R;
`endif
      end
      S_EXEC_I:   w_next_state = S_WB_I;
      S_MEM_ADDR: w_next_state = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) w_next_state = S_WB_MEM;
        else           w_next_state = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) w_next_state = S_FETCH;
        else           w_next_state = S_MEM_WR;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // State register, opcode/funct capture in DECODE, illegal-op pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RESET_STATE;
      r_opcode     <= '0;
      r_illegal_op <= 1'b0;
`ifdef MULTICYCLE_LINK_EN
      r_funct      <= 6'd0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_illegal_op <= w_illegal;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
`ifdef MULTICYCLE_LINK_EN
        r_funct  <= funct;
`endif
      end
    end
  end

  assign illegal_op = r_illegal_op;
  assign state_o    = r_state;

  multicycle_control_outputs u_outputs (
    .i_state         (r_state),
    .i_mem_ready     (mem_ready),
    .i_opcode        (r_opcode),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_branch_ne     (branch_ne),
    .o_pc_src        (pc_src),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_reg_dst       (reg_dst),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op)
  );

endmodule
